// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite ROM read port between the Tom (A)
// and Jerry (B) drawers; round-robin or A-priority grant, tagged fixed-latency return.
module sprite_rom_arbiter #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 12,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prio_a,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   output logic              gnt_a,
   output logic              rvalid_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   output logic              gnt_b,
   output logic              rvalid_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

   ptr_e              ptr_r;
   ptr_e              ptr_nxt_s;
   logic              win_a_s;
   logic              win_b_s;
   logic              accept_s;
   logic              mem_en_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [RD_LAT:0]   tag_vld_r;
   logic [RD_LAT:0]   tag_own_r;
   logic              rvalid_a_r;
   logic              rvalid_b_r;
   logic [DATA_W-1:0] rdata_a_r;
   logic [DATA_W-1:0] rdata_b_r;

   // Grant decision and next round-robin pointer
   always_comb begin
      win_a_s   = 1'b0;
      win_b_s   = 1'b0;
      ptr_nxt_s = ptr_r;
      if (rst) begin
         win_a_s = 1'b0;
      end else if (req_a && req_b) begin
         // forced priority leaves the pointer where it was
         if (prio_a) begin
            win_a_s = 1'b1;
         end else if (ptr_r == PTR_A) begin
            win_a_s   = 1'b1;
            ptr_nxt_s = PTR_B;
         end else begin
            win_b_s   = 1'b1;
            ptr_nxt_s = PTR_A;
         end
      end else if (req_a) begin
         win_a_s   = 1'b1;
         ptr_nxt_s = PTR_B;
      end else if (req_b) begin
         win_b_s   = 1'b1;
         ptr_nxt_s = PTR_A;
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   assign accept_s = win_a_s | win_b_s;
   assign gnt_a    = win_a_s;
   assign gnt_b    = win_b_s;

   // Round-robin pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= PTR_A;
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   // ROM request issue; the address holds while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en_r   <= 1'b0;
         mem_addr_r <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
         mem_en_r   <= 1'b1;
         mem_addr_r <= win_b_s ? addr_b : addr_a;
      end else begin
         mem_en_r   <= 1'b0;
      end
   end

   // Owner tag pipeline, aligned so the last stage matches the ROM word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_r <= {(RD_LAT+1){1'b0}};
         tag_own_r <= {(RD_LAT+1){1'b0}};
      end else begin
         tag_vld_r <= {tag_vld_r[RD_LAT-1:0], accept_s};
         tag_own_r <= {tag_own_r[RD_LAT-1:0], win_b_s};
      end
   end

   // Return routing of each ROM word to its owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_a_r <= 1'b0;
         rvalid_b_r <= 1'b0;
         rdata_a_r  <= {DATA_W{1'b0}};
         rdata_b_r  <= {DATA_W{1'b0}};
      end else if (tag_vld_r[RD_LAT]) begin
         if (tag_own_r[RD_LAT]) begin
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b1;
            rdata_b_r  <= mem_rdata;
         end else begin
            rvalid_a_r <= 1'b1;
            rvalid_b_r <= 1'b0;
            rdata_a_r  <= mem_rdata;
         end
      end else begin
         rvalid_a_r <= 1'b0;
         rvalid_b_r <= 1'b0;
      end
   end

   assign mem_en   = mem_en_r;
   assign mem_addr = mem_addr_r;
   assign rvalid_a = rvalid_a_r;
   assign rvalid_b = rvalid_b_r;
   assign rdata_a  = rdata_a_r;
   assign rdata_b  = rdata_b_r;

endmodule
